// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit hex seven-segment driver
// with frame-aligned word updates, leading-zero blanking and decimal points.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] LAST_P   = PW'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;
    logic [PW-1:0] cur_q;
    logic [PW-1:0] cur_d;

    logic tick;
    logic frame_start;
    logic show;
    logic fd_d;

    logic [4*NUM_DIGITS-1:0] pend_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic [4*NUM_DIGITS-1:0] disp_val_q;
    logic [NUM_DIGITS-1:0]   disp_dp_q;

    logic [4*NUM_DIGITS-1:0] src_val;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    zero_run;
    logic [3:0]              nib;
    logic                    dp_bit;
    logic                    blank;
    logic [6:0]              seg_lit;

    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] sel_d;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h00;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan control: prescaler, digit pointer, first-tick FSM.
    always_comb begin
        cnt_d   = cnt_q;
        p_d     = p_q;
        cur_d   = cur_q;
        state_d = state_q;

        tick        = enable && (cnt_q == LAST_CNT);
        frame_start = tick && (p_q == '0);

        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        if (tick) begin
            p_d   = (p_q == LAST_P) ? '0 : p_q + 1'b1;
            cur_d = p_q;
        end

        unique case (state_q)
            ST_WAIT: if (tick) state_d = ST_SCAN;
            ST_SCAN: state_d = ST_SCAN;
        endcase

        show = enable && (tick || state_q == ST_SCAN);
        fd_d = tick && (p_q == LAST_P);
    end

    // Digit rendering: source word, blanking mask, decode, polarity.
    always_comb begin
        // Digit 0 of a new frame reads pending directly, so the frame
        // is consistent with what the display register is about to hold.
        src_val = frame_start ? pend_val_q : disp_val_q;
        src_dp  = frame_start ? pend_dp_q : disp_dp_q;

        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (src_val[4*i +: 4] == 4'h0);
            lz_mask[i] = blank_lz && zero_run && (i != 0);
        end

        nib    = 4'h0;
        dp_bit = 1'b0;
        blank  = 1'b0;
        onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cur_d == PW'(i)) begin
                nib       = src_val[4*i +: 4];
                dp_bit    = src_dp[i];
                blank     = lz_mask[i];
                onehot[i] = 1'b1;
            end
        end

        seg_lit = blank ? 7'h00 : hex_seg(nib);

        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        sel_d = DIG_OFF;
        if (show) begin
            seg_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
            dp_d  = SEG_ACTIVE_LOW ? ~dp_bit : dp_bit;
            sel_d = DIG_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            p_q     <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            cur_q   <= cur_d;
        end
    end

    // Pending word capture and frame-aligned display transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
        end else begin
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
            end
            if (frame_start) begin
                disp_val_q <= pend_val_q;
                disp_dp_q  <= pend_dp_q;
            end
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            digit_sel  <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_d;
            dp         <= dp_d;
            digit_sel  <= sel_d;
            frame_done <= fd_d;
        end
    end

endmodule
